// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer controller: I/O map, prescaler ratios, field layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timer_pkg;

  // I/O map
  localparam logic [7:0] CFG_ADDR = 8'd4;
  localparam logic [7:0] STS_ADDR = 8'd5;

  // clk cycles per base tick for each basetiempo code
  localparam int PRE0  = 1;
  localparam int PRE1  = 10;
  localparam int PRE2  = 100;
  localparam int PRE3  = 1000;
  localparam int PRE_W = 10;

  // config byte layout
  localparam int UMB_MSB  = 7;
  localparam int UMB_LSB  = 2;
  localparam int BASE_MSB = 1;
  localparam int BASE_LSB = 0;

  // status byte bit positions
  localparam int STS_RUN_BIT = 0;
  localparam int STS_IRQ_BIT = 1;
  localparam int STS_OVR_BIT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // terminal prescaler value for a given time base
  function automatic logic [PRE_W-1:0] pre_last(input logic [1:0] base);
    logic [PRE_W-1:0] last;
    case (base)
      2'd0:    last = PRE_W'(PRE0 - 1);
      2'd1:    last = PRE_W'(PRE1 - 1);
      2'd2:    last = PRE_W'(PRE2 - 1);
      default: last = PRE_W'(PRE3 - 1);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// Prescaler producing one base tick every PREn clk cycles for the selected time base.
// Latency: tick is combinational from the prescaler register; first tick PREn cycles after clr.
// Backpressure: none; clr restarts the period, en low freezes the prescaler.
module tick_gen
  import timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] base_i,
  output logic       tick_o
);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] last;

  assign last   = pre_last(base_i);
  assign tick_o = en_i && (pre_q == last);

  // prescaler next value: clear wins, otherwise count and wrap on tick
  always_comb begin
    pre_d = pre_q;
    if (clr_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = tick_o ? '0 : pre_q + PRE_W'(1);
    end
  end

  // prescaler register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) pre_q <= '0;
    else         pre_q <= pre_d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// Interval timer: config/status I/O registers, periodic base-tick counter, level irq with ack and sticky overrun.
// Latency: timer_end/irq one cycle after the expiring tick; io_rdata one cycle after io_rd.
// Backpressure: none; a config write always takes effect and suppresses a coincident expiry.
module timer_ctrl
  import timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] io_addr_i,
  input  logic       io_wr_i,
  input  logic       io_rd_i,
  input  logic [7:0] io_wdata_i,
  output logic [7:0] io_rdata_o,
  output logic       irq_o,
  input  logic       irq_ack_i,
  output logic       timer_end_o
);

  state_t     state_q, state_d;
  logic [7:0] cfg_q, cfg_d;
  logic [5:0] count_q, count_d;
  logic       irq_q, irq_d;
  logic       ovr_q, ovr_d;
  logic       te_q, te_d;
  logic [7:0] rdata_q, rdata_d;

  logic       cfg_wr, sts_rd, run, tick, expiry;
  logic [5:0] umbral, wr_umbral;
  logic [1:0] base;
  logic [7:0] sts;

  assign cfg_wr    = io_wr_i && (io_addr_i == CFG_ADDR);
  assign sts_rd    = io_rd_i && (io_addr_i == STS_ADDR);
  assign umbral    = cfg_q[UMB_MSB:UMB_LSB];
  assign base      = cfg_q[BASE_MSB:BASE_LSB];
  assign wr_umbral = io_wdata_i[UMB_MSB:UMB_LSB];

  tick_gen u_tick_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (cfg_wr),
    .en_i    (run),
    .base_i  (base),
    .tick_o  (tick)
  );

  // a write on the expiring cycle restarts the period instead of recording the event
  assign expiry = tick && !cfg_wr && (count_q == umbral - 6'd1);

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: only config writes move between IDLE and RUN
  always_comb begin
    state_d = state_q;
    if (cfg_wr) state_d = (wr_umbral != 6'd0) ? ST_RUN : ST_IDLE;
  end

  // FSM output: counting enable
  always_comb begin
    run = (state_q == ST_RUN);
  end

  // config, base-tick counter, irq/overrun and read-data next state
  always_comb begin
    cfg_d   = cfg_q;
    count_d = count_q;
    irq_d   = irq_q;
    ovr_d   = ovr_q;
    te_d    = expiry;
    rdata_d = rdata_q;

    sts              = 8'h00;
    sts[STS_RUN_BIT] = run;
    sts[STS_IRQ_BIT] = irq_q;
    sts[STS_OVR_BIT] = ovr_q;

    if (cfg_wr) begin
      cfg_d   = io_wdata_i;
      count_d = 6'd0;
    end else if (tick) begin
      count_d = expiry ? 6'd0 : count_q + 6'd1;
    end

    // reading status clears overrun; a new overrun in the same cycle takes priority
    if (sts_rd) ovr_d = 1'b0;
    if (expiry) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack_i) ovr_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end

    // reads see the values from before any same-cycle write
    if (io_rd_i) begin
      case (io_addr_i)
        CFG_ADDR: rdata_d = cfg_q;
        STS_ADDR: rdata_d = sts;
        default:  rdata_d = 8'h00;
      endcase
    end
  end

  // datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cfg_q   <= 8'h00;
      count_q <= 6'd0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      te_q    <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      cfg_q   <= cfg_d;
      count_q <= count_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
      te_q    <= te_d;
      rdata_q <= rdata_d;
    end
  end

  assign io_rdata_o  = rdata_q;
  assign irq_o       = irq_q;
  assign timer_end_o = te_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus random traffic against an elapsed-time reference model.
// Latency: checks every output one cycle after each applied input vector.
// Backpressure: n/a.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] io_addr;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       irq;
  logic       irq_ack;
  logic       timer_end;

  int vectors    = 0;
  int miscompares = 0;

  // reference model: expiry happens whenever the cycles elapsed since the
  // last config write are a whole multiple of umbral*prescale
  logic [7:0] m_cfg;
  logic       m_run, m_irq, m_ovr, m_te;
  logic [7:0] m_rdata;
  int         m_el;

  timer_ctrl dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .io_addr_i   (io_addr),
    .io_wr_i     (io_wr),
    .io_rd_i     (io_rd),
    .io_wdata_i  (io_wdata),
    .io_rdata_o  (io_rdata),
    .irq_o       (irq),
    .irq_ack_i   (irq_ack),
    .timer_end_o (timer_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = 8'h00; m_run = 1'b0; m_irq = 1'b0; m_ovr = 1'b0;
    m_te = 1'b0; m_rdata = 8'h00; m_el = 0;
  endtask

  function automatic int period(input logic [7:0] cfg);
    int pre;
    case (cfg[1:0])
      2'd0: pre = 1;
      2'd1: pre = 10;
      2'd2: pre = 100;
      default: pre = 1000;
    endcase
    return int'(cfg[7:2]) * pre;
  endfunction

  // apply one cycle of inputs, advance the model, check all outputs after the edge
  task automatic cyc(input logic wr, input logic rd, input logic [7:0] addr,
                     input logic [7:0] wdata, input logic ack);
    logic cw, ex;
    io_wr = wr; io_rd = rd; io_addr = addr; io_wdata = wdata; irq_ack = ack;
    cw = wr && (addr == 8'd4);
    ex = m_run && !cw && (m_el % period(m_cfg) == 0);
    if (rd) begin
      if (addr == 8'd4)      m_rdata = m_cfg;
      else if (addr == 8'd5) m_rdata = {5'b0, m_ovr, m_irq, m_run};
      else                   m_rdata = 8'h00;
    end
    if (rd && addr == 8'd5) m_ovr = 1'b0;
    if (ex) begin
      if (m_irq && !ack) m_ovr = 1'b1;
      m_irq = 1'b1;
    end else if (ack) begin
      m_irq = 1'b0;
    end
    m_te = ex;
    if (cw) begin
      m_cfg = wdata;
      m_run = (wdata[7:2] != 6'd0);
      m_el  = 1;
    end else if (m_run) begin
      m_el++;
    end
    @(posedge clk); #1;
    chk("irq", {7'b0, irq}, {7'b0, m_irq});
    chk("timer_end", {7'b0, timer_end}, {7'b0, m_te});
    chk("io_rdata", io_rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1; io_addr = 8'h00; io_wr = 1'b0; io_rd = 1'b0;
    io_wdata = 8'h00; irq_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_te", {7'b0, timer_end}, 8'h00);
    chk("rst_rdata", io_rdata, 8'h00);
    reset = 1'b0;

    // umbral=3 base=00: expiries every 3 cycles, first timer_end 4 cycles after the write
    cyc(1'b1, 1'b0, 8'd4, 8'h0C, 1'b0);
    idle(2);
    chk("te_before_k4", {7'b0, timer_end}, 8'h00);
    idle(1);
    chk("te_k4", {7'b0, timer_end}, 8'h01);
    chk("irq_k4", {7'b0, irq}, 8'h01);
    idle(6);
    cyc(1'b0, 1'b1, 8'd4, 8'h00, 1'b0);
    chk("rd_cfg", io_rdata, 8'h0C);

    // asynchronous reset in the middle of a cycle while running with irq pending
    #3 reset = 1'b1;
    #1;
    chk("arst_irq", {7'b0, irq}, 8'h00);
    chk("arst_te", {7'b0, timer_end}, 8'h00);
    chk("arst_rdata", io_rdata, 8'h00);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(10);

    // umbral=1 base=01: one expiry every 10 cycles
    cyc(1'b1, 1'b0, 8'd4, 8'h05, 1'b0);
    idle(9);
    chk("te_base01_early", {7'b0, timer_end}, 8'h00);
    idle(1);
    chk("te_base01", {7'b0, timer_end}, 8'h01);
    idle(1);
    cyc(1'b0, 1'b1, 8'd5, 8'h00, 1'b0);
    chk("sts_irq_run", io_rdata, 8'h03);
    idle(20);
    cyc(1'b0, 1'b1, 8'd5, 8'h00, 1'b0);
    chk("sts_overrun", io_rdata, 8'h07);
    cyc(1'b0, 1'b1, 8'd5, 8'h00, 1'b0);
    chk("sts_ovr_cleared", io_rdata, 8'h03);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("irq_acked", {7'b0, irq}, 8'h00);

    // ack on the expiry cycle consumes the old event only
    idle(4);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("ack_on_expiry_irq", {7'b0, irq}, 8'h01);
    cyc(1'b0, 1'b1, 8'd5, 8'h00, 1'b0);
    chk("ack_on_expiry_sts", io_rdata, 8'h03);

    // umbral=0 stops the timer
    cyc(1'b1, 1'b0, 8'd4, 8'h00, 1'b0);
    idle(30);
    cyc(1'b0, 1'b1, 8'd5, 8'h00, 1'b0);
    chk("sts_idle", io_rdata, 8'h02);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // config write landing on an expiry cycle restarts the period
    cyc(1'b1, 1'b0, 8'd4, 8'h0C, 1'b0);
    idle(5);
    cyc(1'b1, 1'b0, 8'd4, 8'h0C, 1'b0);
    chk("wr_on_expiry_te", {7'b0, timer_end}, 8'h00);
    idle(2);
    chk("restart_te_early", {7'b0, timer_end}, 8'h00);
    idle(1);
    chk("restart_te", {7'b0, timer_end}, 8'h01);

    // simultaneous read and write of config returns the old value
    cyc(1'b1, 1'b1, 8'd4, 8'h2D, 1'b0);
    chk("rd_wr_same_cycle", io_rdata, 8'h0C);
    cyc(1'b1, 1'b0, 8'd5, 8'hFF, 1'b0);
    cyc(1'b0, 1'b1, 8'd9, 8'h00, 1'b0);
    chk("rd_other_addr", io_rdata, 8'h00);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic       wr, rd, ack;
      logic [7:0] addr, wdata;
      r = int'($urandom_range(0, 99));
      wr = 1'b0; rd = 1'b0; ack = ($urandom_range(0, 19) == 0);
      addr = 8'h00; wdata = 8'h00;
      if (r < 3) begin
        wr = 1'b1; addr = 8'd4;
        wdata = {6'($urandom_range(0, 5)), 2'($urandom_range(0, 1))};
        rd = ($urandom_range(0, 3) == 0);
      end else if (r < 5) begin
        wr = 1'b1; addr = ($urandom_range(0, 1) == 0) ? 8'd5 : 8'd9;
        wdata = 8'($urandom);
      end else if (r < 15) begin
        rd = 1'b1;
        case ($urandom_range(0, 2))
          0: addr = 8'd4;
          1: addr = 8'd5;
          default: addr = 8'd7;
        endcase
      end
      cyc(wr, rd, addr, wdata, ack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
